cosx_controller: RTL



---
 rtl/cosx_pkg.sv | 50 +++++
 rtl/cosx_controller.sv | 91 +++++++++
 2 files changed

// File: rtl/cosx_pkg.sv
// Shared encodings for the cosx Taylor-series controller and its datapath:
// FSM states, multiplier-select / accumulator-op constants and the output decode.
package cosx_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_MUL_X = 3'd2;
    localparam logic [2:0] S_MUL_C = 3'd3;
    localparam logic [2:0] S_ACC   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic SEL_X    = 1'b0;
    localparam logic SEL_COEF = 1'b1;
    localparam logic OP_SUB   = 1'b0;
    localparam logic OP_ADD   = 1'b1;

    typedef struct packed {
        logic ready;
        logic done;
        logic timeout;
        logic init;
        logic cnt_en;
        logic ldt;
        logic select;
        logic ldr;
        logic add_sub;
    } ctrl_t;

    // Moore decode; any encoding outside the six states looks like IDLE.
    function automatic ctrl_t decode_ctrl(input logic [2:0] state,
                                          input logic       phase,
                                          input logic       to_flag);
        ctrl_t c;
        c = '0;
        case (state)
            S_INIT:  c.init = 1'b1;
            S_MUL_X: begin c.ldt = 1'b1; c.select = SEL_X;    end
            S_MUL_C: begin c.ldt = 1'b1; c.select = SEL_COEF; end
            S_ACC: begin
                c.ldr     = 1'b1;
                c.cnt_en  = 1'b1;
                c.add_sub = phase ? OP_ADD : OP_SUB;
            end
            S_DONE: begin c.done = 1'b1; c.timeout = to_flag; end
            default: c.ready = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cosx_controller.sv
// Control FSM for the cosx datapath: sequences MUL_X -> MUL_C -> ACC per term,
// alternating the accumulator sign, with a term-count guard forcing termination.
module cosx_controller
    import cosx_pkg::*;
#(
    parameter int MAX_TERMS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic Co,
    input  logic Compare,
    output logic ready,
    output logic done,
    output logic timeout,
    output logic init,
    output logic cnt_en,
    output logic ldt,
    output logic select,
    output logic ldr,
    output logic add_sub
);

    localparam logic [3:0] MAX_T = 4'(MAX_TERMS);

    logic [2:0] state_q, state_d;
    logic       phase_q, phase_d;
    logic [3:0] guard_q, guard_d;
    logic       timeout_q, timeout_d;
    logic [3:0] guard_inc;
    ctrl_t      ctrl;

    // Handshake: start is sampled only while ready=1 (IDLE); a start seen in any
    // other state is dropped, and done is a single-cycle pulse with no back-pressure.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        guard_d   = guard_q;
        timeout_d = timeout_q;
        guard_inc = guard_q + 4'd1;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT: begin
                phase_d   = 1'b0;
                guard_d   = 4'd0;
                timeout_d = 1'b0;
                state_d   = S_MUL_X;
            end
            S_MUL_X: state_d = S_MUL_C;
            S_MUL_C: state_d = S_ACC;
            S_ACC: begin
                phase_d = ~phase_q;
                guard_d = guard_inc;
                if (Co || Compare || (guard_inc == MAX_T)) begin
                    state_d   = S_DONE;
                    timeout_d = !Co && !Compare;
                end else begin
                    state_d = S_MUL_X;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            guard_q   <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            guard_q   <= guard_d;
            timeout_q <= timeout_d;
        end
    end

    assign ctrl    = decode_ctrl(state_q, phase_q, timeout_q);
    assign ready   = ctrl.ready;
    assign done    = ctrl.done;
    assign timeout = ctrl.timeout;
    assign init    = ctrl.init;
    assign cnt_en  = ctrl.cnt_en;
    assign ldt     = ctrl.ldt;
    assign select  = ctrl.select;
    assign ldr     = ctrl.ldr;
    assign add_sub = ctrl.add_sub;

endmodule
